// File: rtl/mem_arbiter_n_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n_pkg
// Shared definitions for the N-channel byte-serial memory arbiter:
//   ADDR_LEN / DATA_LEN / MEM_LEN  - address, channel data and memory bus widths
//   IO_MASK                        - address bits that select the UART region
//   len_e                          - channel transfer-length encoding
//   state_e                        - arbiter FSM state encoding
//   len_bytes()                    - length code to byte count
//   is_io()                        - UART region decode
// ---------------------------------------------------------------------------
package mem_arbiter_n_pkg;

   localparam int ADDR_LEN = 32;
   localparam int DATA_LEN = 32;
   localparam int MEM_LEN  = 8;

   // Writes whose address has both of these bits set go to the UART and
   // must wait while its buffer is full.
   localparam logic [ADDR_LEN-1:0] IO_MASK = 32'h0003_0000;

   typedef enum logic [1:0] {
      LEN_1B  = 2'd0,
      LEN_2B  = 2'd1,
      LEN_4B  = 2'd2,
      LEN_4BX = 2'd3
   } len_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      case (len_e'(len))
         LEN_1B:  return 3'd1;
         LEN_2B:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_io(input logic [ADDR_LEN-1:0] addr);
      return (addr & IO_MASK) == IO_MASK;
   endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n_if
// Byte-wide memory bus between the arbiter and the memory/UART.
//   mem_a          - byte address
//   mem_dout       - write data towards memory
//   mem_wr         - write strobe, one byte per asserted cycle
//   mem_din        - read data; returns the byte addressed on the previous
//                    enabled (ready=1) cycle
//   io_buffer_full - UART cannot accept a byte this cycle
// master: arbiter side, slave: memory side.
// ---------------------------------------------------------------------------
interface mem_arbiter_n_if;
   import mem_arbiter_n_pkg::*;

   logic [ADDR_LEN-1:0] mem_a;
   logic [MEM_LEN-1:0]  mem_dout;
   logic                mem_wr;
   logic [MEM_LEN-1:0]  mem_din;
   logic                io_buffer_full;

   modport master (
      output mem_a, mem_dout, mem_wr,
      input  mem_din, io_buffer_full
   );

   modport slave (
      input  mem_a, mem_dout, mem_wr,
      output mem_din, io_buffer_full
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational grant selection.
//   req   [NCH]   - level requests
//   ptr   [PTR_W] - round-robin start index (ignored when ARB_MODE=0)
//   grant [NCH]   - one-hot grant, all zero when nobody requests
// ARB_MODE=0: lowest requesting index wins.
// ARB_MODE=1: first requester at or after ptr, wrapping at NCH.
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NCH      = 2,
   parameter  int ARB_MODE = 1,
   localparam int PTR_W    = $clog2(NCH)
) (
   input  logic [NCH-1:0]   req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NCH-1:0]   grant
);

   localparam logic [PTR_W:0] NCH_W = (PTR_W + 1)'(NCH);

   logic [PTR_W-1:0] start;
   logic [PTR_W:0]   pos;
   logic             found;

   // Fixed priority is round-robin with the search always starting at 0.
   assign start = (ARB_MODE == 0) ? '0 : ptr;

   always_comb begin
      grant = '0;
      found = 1'b0;
      pos   = '0;
      for (int i = 0; i < NCH; i++) begin
         // start < NCH and i < NCH, so a single subtraction wraps the index.
         pos = {1'b0, start} + (PTR_W + 1)'(i);
         if (pos >= NCH_W) begin
            pos = pos - NCH_W;
         end
         if (!found && req[pos[PTR_W-1:0]]) begin
            grant[pos[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n
// Arbitrates NCH requesters onto a single byte-wide memory bus and performs
// 1/2/4-byte little-endian reads and writes one byte per cycle.
//   clk, reset  - clock, asynchronous active-low reset
//   ready       - global enable; low freezes all state and masks mem_wr
//   clear       - mispredict flush: aborts reads, blocks new grants
//   ch_req      - per-channel level request, held until its ch_done
//   ch_we       - 1 = write, 0 = read
//   ch_addr     - byte address, channel i in [32i+31:32i]
//   ch_len      - 0:1 byte, 1:2 bytes, 2/3:4 bytes
//   ch_wdata    - write data, byte 0 goes to the lowest address
//   ch_done     - one-cycle completion pulse for the granted channel
//   ch_rdata    - zero-extended read data, valid while ch_done is high
//   mem         - byte memory bus (mem_a, mem_dout, mem_wr, mem_din,
//                 io_buffer_full)
// Reads take N+1 cycles in RD: address for byte k goes out in cycle k and
// its data arrives on mem_din in cycle k+1. Writes take N cycles in WR, with
// UART-region bytes held back while io_buffer_full is high.
// ---------------------------------------------------------------------------
module mem_arbiter_n
   import mem_arbiter_n_pkg::*;
#(
   parameter int NCH      = 2,
   parameter int ARB_MODE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ready,
   input  logic                    clear,
   input  logic [NCH-1:0]          ch_req,
   input  logic [NCH-1:0]          ch_we,
   input  logic [NCH*ADDR_LEN-1:0] ch_addr,
   input  logic [NCH*2-1:0]        ch_len,
   input  logic [NCH*DATA_LEN-1:0] ch_wdata,
   output logic [NCH-1:0]          ch_done,
   output logic [DATA_LEN-1:0]     ch_rdata,
   mem_arbiter_n_if.master         mem
);

   localparam int               PTR_W    = $clog2(NCH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCH - 1);

   state_e              state;
   logic [PTR_W-1:0]    ptr;
   logic [NCH-1:0]      grant;
   logic [NCH-1:0]      grant_q;
   logic [2:0]          k;
   logic [ADDR_LEN-1:0] mem_a_q;
   logic [MEM_LEN-1:0]  mem_dout_q;
   logic                mem_wr_q;

   logic [ADDR_LEN-1:0] addr_q;
   logic [DATA_LEN-1:0] wdata_q;
   logic [2:0]          nbytes_q;
   logic [DATA_LEN-1:0] rdata_q;

   logic                grant_now;
   logic [PTR_W-1:0]    gidx;
   logic [PTR_W-1:0]    next_ptr;
   logic                sel_we;
   logic [ADDR_LEN-1:0] sel_addr;
   logic [1:0]          sel_len;
   logic [DATA_LEN-1:0] sel_wdata;
   logic [2:0]          k_inc;
   logic [ADDR_LEN-1:0] addr_k1;
   logic [DATA_LEN-1:0] rdata_cap;
   logic [MEM_LEN-1:0]  wbyte_next;
   logic                wr_blocked;

   rr_arbiter #(
      .NCH      (NCH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .req   (ch_req),
      .ptr   (ptr),
      .grant (grant)
   );

   assign grant_now = !clear && (|ch_req);

   // Pick the granted channel's request fields.
   always_comb begin
      gidx      = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_len   = '0;
      sel_wdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            gidx      = PTR_W'(i);
            sel_we    = ch_we[i];
            sel_addr  = ch_addr[i*ADDR_LEN +: ADDR_LEN];
            sel_len   = ch_len[i*2 +: 2];
            sel_wdata = ch_wdata[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

   assign next_ptr = (gidx == PTR_LAST) ? '0 : gidx + PTR_W'(1);

   assign k_inc   = k + 3'd1;
   // Address arithmetic wraps naturally at 2^32.
   assign addr_k1 = addr_q + {{(ADDR_LEN-3){1'b0}}, k_inc};

   // mem_din in cycle k carries the byte addressed in cycle k-1.
   always_comb begin
      rdata_cap = rdata_q;
      case (k)
         3'd1:    rdata_cap[7:0]   = mem.mem_din;
         3'd2:    rdata_cap[15:8]  = mem.mem_din;
         3'd3:    rdata_cap[23:16] = mem.mem_din;
         3'd4:    rdata_cap[31:24] = mem.mem_din;
         default: ;
      endcase
   end

   always_comb begin
      case (k_inc)
         3'd1:    wbyte_next = wdata_q[15:8];
         3'd2:    wbyte_next = wdata_q[23:16];
         3'd3:    wbyte_next = wdata_q[31:24];
         default: wbyte_next = wdata_q[7:0];
      endcase
   end

   assign wr_blocked = is_io(addr_q) && mem.io_buffer_full;

   // The strobe is registered; ready and the UART back-pressure are applied
   // on the way out so they act in the same cycle they are seen.
   assign mem.mem_a    = mem_a_q;
   assign mem.mem_dout = mem_dout_q;
   assign mem.mem_wr   = mem_wr_q && ready && !wr_blocked;

   // Request datapath latches; no reset, only meaningful after a grant.
   always_ff @(posedge clk) begin
      if (ready) begin
         if (state == ST_IDLE && grant_now) begin
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            nbytes_q <= len_bytes(sel_len);
            rdata_q  <= '0;
         end else if (state == ST_RD && k != 3'd0) begin
            rdata_q  <= rdata_cap;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         k          <= '0;
         grant_q    <= '0;
         ch_done    <= '0;
         ch_rdata   <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
      end else if (ready) begin
         case (state)
            ST_IDLE: begin
               if (grant_now) begin
                  grant_q <= grant;
                  k       <= '0;
                  mem_a_q <= sel_addr;
                  if (ARB_MODE != 0) begin
                     ptr <= next_ptr;
                  end
                  if (sel_we) begin
                     state      <= ST_WR;
                     mem_dout_q <= sel_wdata[7:0];
                     mem_wr_q   <= 1'b1;
                  end else begin
                     state      <= ST_RD;
                     mem_dout_q <= '0;
                     mem_wr_q   <= 1'b0;
                  end
               end
            end

            ST_RD: begin
               if (clear) begin
                  // Speculative read is dropped; ptr keeps its post-grant value.
                  state   <= ST_IDLE;
                  k       <= '0;
                  grant_q <= '0;
                  mem_a_q <= '0;
               end else if (k == nbytes_q) begin
                  state    <= ST_DONE;
                  ch_done  <= grant_q;
                  ch_rdata <= rdata_cap;
                  mem_a_q  <= '0;
               end else begin
                  k       <= k_inc;
                  mem_a_q <= (k_inc < nbytes_q) ? addr_k1 : '0;
               end
            end

            ST_WR: begin
               // Committed stores ignore clear and always run to DONE.
               if (!wr_blocked) begin
                  if (k_inc == nbytes_q) begin
                     state      <= ST_DONE;
                     ch_done    <= grant_q;
                     ch_rdata   <= '0;
                     mem_a_q    <= '0;
                     mem_dout_q <= '0;
                     mem_wr_q   <= 1'b0;
                  end else begin
                     k          <= k_inc;
                     mem_a_q    <= addr_k1;
                     mem_dout_q <= wbyte_next;
                  end
               end
            end

            ST_DONE: begin
               state    <= ST_IDLE;
               k        <= '0;
               grant_q  <= '0;
               ch_done  <= '0;
               ch_rdata <= '0;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
